// File: rtl/delay_seq_pkg.sv
// ---------------------------------------------------------------------------
// delay_seq_pkg
//   Shared definitions for the delay-generator discharge sequencer:
//   default channel count and counter width, FSM state encodings and a
//   helper that sizes the channel-address bus.
//   No ports (package).
// ---------------------------------------------------------------------------
package delay_seq_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_COUNT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Address width for a channel index; never zero so a single-channel
  // build still has a legal port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_ch_slot.sv
// ---------------------------------------------------------------------------
// delay_ch_slot
//   One delay channel: compares the running count against the channel's
//   shadow delay, fires once per sequence and stretches the discharge-reset
//   pulse to RST_PULSE cycles.
// Ports
//   i_clk       clock
//   i_reset     asynchronous active-high reset
//   i_clear     start of a new sequence: re-arm the channel
//   i_active    channel enabled for this sequence
//   i_count_en  sequencer is in its counting state
//   i_delay     programmed delay (cycles)
//   i_count     elapsed-cycle count
//   o_reset     discharge-reset pulse
//   o_fired     channel finished firing (or disabled)
// ---------------------------------------------------------------------------
module delay_ch_slot #(
  parameter int CNT_W     = 16,
  parameter int RST_PULSE = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_active,
  input  logic             i_count_en,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_reset,
  output logic             o_fired
);

  localparam int PW = $clog2(RST_PULSE + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE);

  logic          fired_q, fired_d;
  logic [PW-1:0] pulse_q, pulse_d;

  always_comb begin
    fired_d = fired_q;
    pulse_d = pulse_q;
    if (pulse_q != '0) pulse_d = pulse_q - PW'(1);
    if (i_clear) begin
      fired_d = 1'b0;
      pulse_d = '0;
    end else if (i_count_en && i_active && !fired_q && (i_count == i_delay)) begin
      fired_d = 1'b1;
      pulse_d = PULSE_LOAD;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fired_q <= 1'b0;
      pulse_q <= '0;
    end else begin
      fired_q <= fired_d;
      pulse_q <= pulse_d;
    end
  end

  // Registered down-counter: high for exactly RST_PULSE cycles after the match.
  assign o_reset = (pulse_q != '0);
  // A disabled channel never blocks completion.
  assign o_fired = fired_q | ~i_active;

endmodule

// File: rtl/delay_seq_ctrl.sv
// ---------------------------------------------------------------------------
// delay_seq_ctrl
//   First-charge/discharge sequencer. Latches per-channel delays and the
//   channel mask on a trigger, waits for the start-counter level, counts
//   cycles and emits a per-channel discharge-reset pulse when each delay
//   expires.
//   Optional feature macro: DELAY_SEQ_TIMEOUT_EN (bounded ARMED wait).
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_trig                    start trigger (level-sampled in IDLE)
//   i_startcounter            start-counter level from the charge stage
//   i_cfg_we/addr/data        staging-register write port
//   i_ch_en                   channel enable mask, sampled at trigger
//   o_reset_ch                per-channel discharge reset pulses
//   o_busy                    sequence in progress
//   o_done                    1-cycle completion pulse
//   o_retrig                  1-cycle pulse, trigger ignored while busy
//   o_timeout                 1-cycle pulse, ARMED wait expired
//   o_count                   elapsed-cycle count
// ---------------------------------------------------------------------------
module delay_seq_ctrl
  import delay_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_PULSE   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_trig,
  input  logic                          i_startcounter,
  input  logic                          i_cfg_we,
  input  logic [addr_width(NUM_CH)-1:0] i_cfg_addr,
  input  logic [CNT_W-1:0]              i_cfg_data,
  input  logic [NUM_CH-1:0]             i_ch_en,
  output logic [NUM_CH-1:0]             o_reset_ch,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_retrig,
  output logic                          o_timeout,
  output logic [CNT_W-1:0]              o_count
);

  localparam int AW = addr_width(NUM_CH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]  mask_q;
  logic               retrig_q;
  logic [CNT_W-1:0]   staging_q [NUM_CH];
  logic [CNT_W-1:0]   shadow_q  [NUM_CH];
  logic [NUM_CH-1:0]  fired;
  logic               accept;
  logic               wait_expired;

  assign accept = (state_q == ST_IDLE) && i_trig;

  // Staging and shadow delay registers, one pair per channel. A write that
  // lands in the trigger cycle is forwarded straight into the shadow copy.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cfg
    logic wr_hit;
    assign wr_hit = i_cfg_we && (i_cfg_addr == AW'(gi));

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        staging_q[gi] <= '0;
        shadow_q[gi]  <= '0;
      end else begin
        if (wr_hit) staging_q[gi] <= i_cfg_data;
        if (accept) shadow_q[gi]  <= wr_hit ? i_cfg_data : staging_q[gi];
      end
    end

    delay_ch_slot #(
      .CNT_W     (CNT_W),
      .RST_PULSE (RST_PULSE)
    ) u_slot (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (accept),
      .i_active   (mask_q[gi]),
      .i_count_en (state_q == ST_COUNT),
      .i_delay    (shadow_q[gi]),
      .i_count    (count_q),
      .o_reset    (o_reset_ch[gi]),
      .o_fired    (fired[gi])
    );
  end

`ifdef DELAY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          timeout_q;

  // wait_q counts ARMED cycles already spent; expiry is judged on the
  // TIMEOUT_CYC-th cycle so a start-counter in that same cycle still wins.
  assign wait_expired = (state_q == ST_ARMED) && !i_startcounter && (wait_q == WAIT_LAST);
  assign wait_d       = (state_q == ST_ARMED) ? wait_q + TW'(1) : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= wait_expired;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
  // Constant zero; TIMEOUT_CYC is referenced only so the parameter stays
  // part of the interface in both builds.
  assign o_timeout    = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_trig) begin
          state_d = ST_ARMED;
          count_d = '0;
        end
      end
      ST_ARMED: begin
        if (i_startcounter) begin
          state_d = ST_COUNT;
          count_d = '0;
        end else if (wait_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (count_q != '1) count_d = count_q + CNT_W'(1);
        // Finish only once every channel has fired and its pulse has ended.
        if ((&fired) && !(|o_reset_ch)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      mask_q   <= '0;
      retrig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      retrig_q <= i_trig && (state_q != ST_IDLE);
      if (accept) mask_q <= i_ch_en;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_retrig = retrig_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_seq_ctrl
//   Directed bench for delay_seq_ctrl (NUM_CH=4, CNT_W=16, RST_PULSE=2,
//   TIMEOUT_CYC=8). Cycle index k counts from the first COUNT cycle (k=0);
//   channel c with delay D is expected high at k = D+1 .. D+2 and o_done at
//   k = (largest enabled delay) + 4, or k = 1 with an empty mask.
// ---------------------------------------------------------------------------
module tb_delay_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_trig;
  logic        i_startcounter;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_addr;
  logic [15:0] i_cfg_data;
  logic [3:0]  i_ch_en;
  logic [3:0]  o_reset_ch;
  logic        o_busy, o_done, o_retrig, o_timeout;
  logic [15:0] o_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] exp_d [4];
  logic [3:0]  exp_en;

  delay_seq_ctrl #(
    .NUM_CH(4), .CNT_W(16), .RST_PULSE(2), .TIMEOUT_CYC(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_trig(i_trig),
    .i_startcounter(i_startcounter), .i_cfg_we(i_cfg_we),
    .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .i_ch_en(i_ch_en),
    .o_reset_ch(o_reset_ch), .o_busy(o_busy), .o_done(o_done),
    .o_retrig(o_retrig), .o_timeout(o_timeout), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
    tick();
    i_cfg_we = 1'b0;
  endtask

  // Trigger, spend two cycles ARMED, then raise start-counter.
  // Leaves the bench in COUNT cycle k=0.
  task automatic start_seq(input logic [3:0] mask);
    i_ch_en = mask; i_trig = 1'b1;
    tick();
    i_trig = 1'b0; i_cfg_we = 1'b0;
    chk("busy_armed", {31'd0, o_busy}, 1);
    chk("count_armed", {16'd0, o_count}, 0);
    tick();
    chk("armed_no_pulse", {28'd0, o_reset_ch}, 0);
    i_startcounter = 1'b1;
    tick();
    i_startcounter = 1'b0;
  endtask

  // Walk the COUNT phase cycle by cycle. retrig_at / wr_at inject a trigger
  // or a ch0=20 config write in that cycle (use 1000 for none).
  task automatic run_seq(input int done_at, input int retrig_at, input int wr_at);
    logic [3:0] exp_rst;
    for (int k = 0; k <= done_at; k++) begin
      exp_rst = '0;
      for (int c = 0; c < 4; c++)
        if (exp_en[c] && k >= int'(exp_d[c]) + 1 && k <= int'(exp_d[c]) + 2) exp_rst[c] = 1'b1;
      chk($sformatf("reset_ch k=%0d", k), {28'd0, o_reset_ch}, {28'd0, exp_rst});
      chk($sformatf("count k=%0d", k), {16'd0, o_count}, k);
      chk($sformatf("done k=%0d", k), {31'd0, o_done}, (k == done_at) ? 1 : 0);
      chk($sformatf("retrig k=%0d", k), {31'd0, o_retrig}, (k == retrig_at + 1) ? 1 : 0);
      i_trig = 1'b0; i_cfg_we = 1'b0;
      if (k == retrig_at) i_trig = 1'b1;
      if (k == wr_at) begin
        i_cfg_we = 1'b1; i_cfg_addr = 2'd0; i_cfg_data = 16'd20;
      end
      tick();
    end
    i_trig = 1'b0; i_cfg_we = 1'b0;
    chk("busy_after_done", {31'd0, o_busy}, 0);
    chk("done_one_cycle", {31'd0, o_done}, 0);
    $display("sequence done_at=%0d mask=%b finished", done_at, exp_en);
  endtask

  initial begin
    i_reset = 1'b1; i_trig = 1'b0; i_startcounter = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0; i_ch_en = '0;
    tick(); tick();
    chk("rst_reset_ch", {28'd0, o_reset_ch}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_count", {16'd0, o_count}, 0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    i_reset = 1'b0;
    tick();

    // Test 1: delays {3,5,5,10}; ch3 written in the trigger cycle itself.
    wr(2'd0, 16'd3); wr(2'd1, 16'd5); wr(2'd2, 16'd5);
    i_cfg_we = 1'b1; i_cfg_addr = 2'd3; i_cfg_data = 16'd10;
    exp_d = '{16'd3, 16'd5, 16'd5, 16'd10}; exp_en = 4'b1111;
    start_seq(4'b1111);
    run_seq(14, 1000, 1000);
    tick();

    // Test 3: same run, trigger pulsed at k=5 must only raise o_retrig.
    start_seq(4'b1111);
    run_seq(14, 5, 1000);
    tick();

    // Test 2: mask 0101, delays {0,7,2,7}.
    wr(2'd0, 16'd0); wr(2'd1, 16'd7); wr(2'd2, 16'd2); wr(2'd3, 16'd7);
    exp_d = '{16'd0, 16'd7, 16'd2, 16'd7}; exp_en = 4'b0101;
    start_seq(4'b0101);
    run_seq(6, 1000, 1000);
    tick();

    // Empty mask: straight through COUNT to DONE.
    exp_en = 4'b0000;
    start_seq(4'b0000);
    run_seq(1, 1000, 1000);
    tick();

    // Test 5: ch0=4, rewritten to 20 during COUNT; next run uses 20.
    wr(2'd0, 16'd4);
    exp_d[0] = 16'd4; exp_en = 4'b0001;
    start_seq(4'b0001);
    run_seq(8, 1000, 2);
    tick();
    exp_d[0] = 16'd20;
    start_seq(4'b0001);
    run_seq(24, 1000, 1000);
    tick();

    // Test 4: reset in the middle of ch2's pulse (ch2 delay still 2).
    start_seq(4'b0100);
    tick(); tick(); tick();
    chk("pre_reset_pulse", {28'd0, o_reset_ch}, 4'b0100);
    #2 i_reset = 1'b1;
    #1;
    chk("async_reset_ch", {28'd0, o_reset_ch}, 0);
    chk("async_reset_busy", {31'd0, o_busy}, 0);
    chk("async_reset_count", {16'd0, o_count}, 0);
    #1 i_reset = 1'b0;
    tick();
    chk("post_reset_idle", {31'd0, o_busy}, 0);
    $display("mid-pulse reset applied");

    // Registers were cleared by reset: every delay is now 0.
    exp_d = '{16'd0, 16'd0, 16'd0, 16'd0}; exp_en = 4'b1111;
    start_seq(4'b1111);
    run_seq(4, 1000, 1000);
    tick();

    // Test 6: no start-counter.
    i_ch_en = 4'b0001; i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
`ifdef DELAY_SEQ_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("armed_wait k=%0d", k), {31'd0, o_busy}, 1);
      chk($sformatf("no_timeout k=%0d", k), {31'd0, o_timeout}, 0);
      tick();
    end
    chk("timeout_pulse", {31'd0, o_timeout}, 1);
    chk("timeout_idle", {31'd0, o_busy}, 0);
    chk("timeout_no_reset", {28'd0, o_reset_ch}, 0);
    tick();
    chk("timeout_one_cycle", {31'd0, o_timeout}, 0);
    chk("timeout_no_done", {31'd0, o_done}, 0);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("armed_forever_busy", {31'd0, o_busy}, 1);
    chk("armed_forever_timeout", {31'd0, o_timeout}, 0);
    chk("armed_forever_reset", {28'd0, o_reset_ch}, 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    chk("armed_exit_idle", {31'd0, o_busy}, 0);
`endif
    $display("ARMED wait behaviour checked");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
